// File: rtl/ps2_top_msx.sv
// ps2_top_msx: PS/2 Set-2 keyboard to MSX 11x8 keyboard-matrix bridge.
// Receives scan codes, tracks key state per matrix bit and answers row
// select Y with the active-low column byte X.
// Optional feature macro: PS2_HOST_TX_EN -- when defined, sends the keyboard
// reset command FF after reset; when undefined, dataout/clkout stay released.
module ps2_top_msx #(
    parameter int TIMEOUT = 20000
) (
    input  logic       CLKi,
    input  logic       RST,
    input  logic       pclk,
    input  logic       data,
    input  logic [3:0] Y,
    output logic [7:0] X,
    output logic       dataout,
    output logic       clkout
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [1:0]    pclk_sync, data_sync;
    logic          pclk_prev, fall, bit_in;
    rx_state_t     rx_state, rx_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg, rx_byte;
    logic [TW-1:0] idle_cnt;
    logic          timed_out, byte_done, rx_valid, tx_active;
    logic          ext, brk;
    logic [2:0]    skip;
    logic [7:0]    key;
    logic [7:0]    matrix [0:8];

    // Synchronize both PS/2 lines and keep a delayed pclk for fall detection
    always_ff @(posedge CLKi) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (RST) begin
            pclk_sync <= 2'b11;
            data_sync <= 2'b11;
            pclk_prev <= 1'b1;
        end else begin
            pclk_sync <= {pclk_sync[0], pclk};
            data_sync <= {data_sync[0], data};
            pclk_prev <= pclk_sync[1];
        end
    end

    assign fall      = pclk_prev & ~pclk_sync[1];
    assign bit_in    = data_sync[1];
    assign timed_out = (idle_cnt == TW'(TIMEOUT));

    // Receiver next state: frame sequencing, error drop and idle timeout
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        rx_nxt    = rx_state;
        byte_done = 1'b0;
        if (tx_active) begin
            rx_nxt = RX_IDLE;
        end else if (fall) begin
            case (rx_state)
                RX_IDLE:   if (!bit_in) rx_nxt = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) rx_nxt = RX_PARITY;
                RX_PARITY: rx_nxt = (^{shift_reg, bit_in}) ? RX_STOP : RX_IDLE;
                RX_STOP: begin
                    rx_nxt    = RX_IDLE;
                    byte_done = bit_in;
                end
                default:   rx_nxt = RX_IDLE;
            endcase
        end else if (rx_state != RX_IDLE && timed_out) begin
            rx_nxt = RX_IDLE;
        end
    end

    // Receiver state register, data shifter and idle-clock counter
    always_ff @(posedge CLKi) begin
        if (RST) begin
            rx_state  <= RX_IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            rx_state <= rx_nxt;
            rx_valid <= byte_done;
            if (byte_done) rx_byte <= shift_reg;
            if (rx_state == RX_IDLE || fall) idle_cnt <= '0;
            else                             idle_cnt <= idle_cnt + TW'(1);
            if (fall && rx_state == RX_IDLE) bit_cnt <= 3'd0;
            if (fall && rx_state == RX_DATA) begin
                shift_reg <= {bit_in, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    // Scan code to matrix position: {hit, row[3:0], column[2:0]}
    function automatic logic [7:0] key_map(input logic e, input logic [7:0] code);
        case ({e, code})
            9'h045: key_map = 8'h80; 9'h016: key_map = 8'h81; 9'h01E: key_map = 8'h82; 9'h026: key_map = 8'h83;
            9'h025: key_map = 8'h84; 9'h02E: key_map = 8'h85; 9'h036: key_map = 8'h86; 9'h03D: key_map = 8'h87;
            9'h03E: key_map = 8'h88; 9'h046: key_map = 8'h89; 9'h04E: key_map = 8'h8A; 9'h055: key_map = 8'h8B;
            9'h05D: key_map = 8'h8C; 9'h054: key_map = 8'h8D; 9'h05B: key_map = 8'h8E; 9'h04C: key_map = 8'h8F;
            9'h052: key_map = 8'h90; 9'h00E: key_map = 8'h91; 9'h041: key_map = 8'h92; 9'h049: key_map = 8'h93;
            9'h04A: key_map = 8'h94; 9'h01C: key_map = 8'h96; 9'h032: key_map = 8'h97;
            9'h021: key_map = 8'h98; 9'h023: key_map = 8'h99; 9'h024: key_map = 8'h9A; 9'h02B: key_map = 8'h9B;
            9'h034: key_map = 8'h9C; 9'h033: key_map = 8'h9D; 9'h043: key_map = 8'h9E; 9'h03B: key_map = 8'h9F;
            9'h042: key_map = 8'hA0; 9'h04B: key_map = 8'hA1; 9'h03A: key_map = 8'hA2; 9'h031: key_map = 8'hA3;
            9'h044: key_map = 8'hA4; 9'h04D: key_map = 8'hA5; 9'h015: key_map = 8'hA6; 9'h02D: key_map = 8'hA7;
            9'h01B: key_map = 8'hA8; 9'h02C: key_map = 8'hA9; 9'h03C: key_map = 8'hAA; 9'h02A: key_map = 8'hAB;
            9'h01D: key_map = 8'hAC; 9'h022: key_map = 8'hAD; 9'h035: key_map = 8'hAE; 9'h01A: key_map = 8'hAF;
            9'h012: key_map = 8'hB0; 9'h059: key_map = 8'hB0; 9'h014: key_map = 8'hB1; 9'h114: key_map = 8'hB1;
            9'h011: key_map = 8'hB2; 9'h058: key_map = 8'hB3; 9'h111: key_map = 8'hB4; 9'h005: key_map = 8'hB5;
            9'h006: key_map = 8'hB6; 9'h004: key_map = 8'hB7;
            9'h00C: key_map = 8'hB8; 9'h003: key_map = 8'hB9; 9'h076: key_map = 8'hBA; 9'h00D: key_map = 8'hBB;
            9'h083: key_map = 8'hBC; 9'h066: key_map = 8'hBD; 9'h00A: key_map = 8'hBE; 9'h05A: key_map = 8'hBF;
            9'h029: key_map = 8'hC0; 9'h16C: key_map = 8'hC1; 9'h170: key_map = 8'hC2; 9'h171: key_map = 8'hC3;
            9'h16B: key_map = 8'hC4; 9'h175: key_map = 8'hC5; 9'h172: key_map = 8'hC6; 9'h174: key_map = 8'hC7;
            default: key_map = 8'h00;
        endcase
    endfunction

    assign key = key_map(ext, rx_byte);

    // Decoder: prefix flags, Pause-sequence skip and matrix bit updates
    always_ff @(posedge CLKi) begin
        if (RST) begin
            // NOTE: the matrix is a flop array, so it is reset explicitly row by row.
            for (int r = 0; r < 9; r++) matrix[r] <= 8'hFF;
            ext  <= 1'b0;
            brk  <= 1'b0;
            skip <= 3'd0;
        end else if (rx_valid) begin
            if (skip != 3'd0) begin
                skip <= skip - 3'd1;
            end else begin
                case (rx_byte)
                    8'hE0: ext <= 1'b1;
                    8'hF0: brk <= 1'b1;
                    8'hE1: skip <= 3'd7;    // rest of E1 14 77 E1 F0 14 F0 77
                    8'hAA, 8'hFA, 8'hEE: ;  // keyboard responses, not keys
                    default: begin
                        if (key[7]) matrix[key[6:3]][key[2:0]] <= brk;
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Row readout; keypad rows and out-of-range selects read as released
    always_comb begin
        X = 8'hFF;
        if (!RST && Y <= 4'd8) X = matrix[Y];
    end

`ifdef PS2_HOST_TX_EN
    typedef enum logic [2:0] {TX_WAIT, TX_INHIBIT, TX_REQ, TX_SHIFT, TX_ACK, TX_DONE} tx_state_t;
    localparam int WAIT_CLKS    = 10;    // 1 us at 10 MHz
    localparam int INHIBIT_CLKS = 1000;  // 100 us at 10 MHz
    localparam int CW           = (TW > 10) ? TW : 10;

    tx_state_t     tx_state, tx_nxt;
    logic [CW-1:0] tx_cnt;
    logic [8:0]    tx_shift;
    logic [3:0]    tx_bits;
    logic          tx_out;

    // Transmitter state register, bit shifter and phase counter
    always_ff @(posedge CLKi) begin
        if (RST) begin
            tx_state <= TX_WAIT;
            tx_cnt   <= '0;
            tx_shift <= 9'h1FF;  // FF with odd parity bit 1
            tx_bits  <= 4'd0;
            tx_out   <= 1'b1;
        end else begin
            tx_state <= tx_nxt;
            if (tx_nxt != tx_state || (fall && (tx_state == TX_SHIFT || tx_state == TX_ACK)))
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + CW'(1);
            if (tx_state == TX_REQ) begin
                tx_out <= 1'b0;
            end else if (tx_state == TX_SHIFT && fall) begin
                tx_out   <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bits  <= tx_bits + 4'd1;
            end
        end
    end

    // Transmitter next state and open-drain line drives
    always_comb begin
        tx_nxt  = tx_state;
        dataout = 1'b1;
        clkout  = 1'b1;
        case (tx_state)
            TX_WAIT:    if (tx_cnt == CW'(WAIT_CLKS - 1)) tx_nxt = TX_INHIBIT;
            TX_INHIBIT: begin
                clkout = 1'b0;
                if (tx_cnt == CW'(INHIBIT_CLKS - 1)) tx_nxt = TX_REQ;
            end
            TX_REQ: begin
                clkout  = 1'b0;
                dataout = 1'b0;
                tx_nxt  = TX_SHIFT;
            end
            TX_SHIFT: begin
                dataout = tx_out;
                if (fall && tx_bits == 4'd9)        tx_nxt = TX_ACK;
                else if (tx_cnt == CW'(TIMEOUT))    tx_nxt = TX_DONE;
            end
            TX_ACK:     if (fall || tx_cnt == CW'(TIMEOUT)) tx_nxt = TX_DONE;
            default:    tx_nxt = TX_DONE;
        endcase
        if (RST) begin
            dataout = 1'b1;
            clkout  = 1'b1;
        end
    end

    assign tx_active = (tx_state != TX_DONE);
`else
    assign tx_active = 1'b0;
    assign dataout   = 1'b1;
    assign clkout    = 1'b1;
`endif

endmodule

// File: tb/tb_ps2_top_msx.sv
// tb_ps2_top_msx: directed PS/2 frames against a scan-code-level model of
// the MSX matrix; one compare process checks X and the line drives every cycle.
`timescale 1ns/1ps
module tb_ps2_top_msx;
    localparam int TIMEOUT = 20000;

    logic       CLKi = 1'b0;
    logic       RST  = 1'b1;
    logic       pclk = 1'b1;
    logic       data = 1'b1;
    logic [3:0] Y    = 4'd0;
    logic [7:0] X;
    logic       dataout, clkout;

    ps2_top_msx #(.TIMEOUT(TIMEOUT)) dut (
        .CLKi(CLKi), .RST(RST), .pclk(pclk), .data(data),
        .Y(Y), .X(X), .dataout(dataout), .clkout(clkout)
    );

    always #50 CLKi = ~CLKi;

    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    // Model: expected column byte per row select, prefix flags, key table
    logic [7:0] model_m [0:15];
    bit         m_ext, m_brk;
    logic [8:0] keytab [0:8][0:7];  // {ext, code}, element k is column 7-k
    logic [8:0] alias_key [0:1];
    int         alias_row [0:1];
    int         alias_col [0:1];

    initial begin
        keytab[0] = '{9'h03D, 9'h036, 9'h02E, 9'h025, 9'h026, 9'h01E, 9'h016, 9'h045};
        keytab[1] = '{9'h04C, 9'h05B, 9'h054, 9'h05D, 9'h055, 9'h04E, 9'h046, 9'h03E};
        keytab[2] = '{9'h032, 9'h01C, 9'h000, 9'h04A, 9'h049, 9'h041, 9'h00E, 9'h052};
        keytab[3] = '{9'h03B, 9'h043, 9'h033, 9'h034, 9'h02B, 9'h024, 9'h023, 9'h021};
        keytab[4] = '{9'h02D, 9'h015, 9'h04D, 9'h044, 9'h031, 9'h03A, 9'h04B, 9'h042};
        keytab[5] = '{9'h01A, 9'h035, 9'h022, 9'h01D, 9'h02A, 9'h03C, 9'h02C, 9'h01B};
        keytab[6] = '{9'h004, 9'h006, 9'h005, 9'h111, 9'h058, 9'h011, 9'h014, 9'h012};
        keytab[7] = '{9'h05A, 9'h00A, 9'h066, 9'h083, 9'h00D, 9'h076, 9'h003, 9'h00C};
        keytab[8] = '{9'h174, 9'h172, 9'h175, 9'h16B, 9'h171, 9'h170, 9'h16C, 9'h029};
        alias_key[0] = 9'h114; alias_row[0] = 6; alias_col[0] = 1;  // right CTRL
        alias_key[1] = 9'h059; alias_row[1] = 6; alias_col[1] = 0;  // right SHIFT
    end

    task automatic model_reset();
        for (int r = 0; r < 16; r++) model_m[r] = 8'hFF;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [8:0] k;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hE1) begin
        end else begin
            k = {m_ext, b};
            for (int r = 0; r < 9; r++)
                for (int c = 0; c < 8; c++)
                    if (keytab[r][c] != 9'h000 && keytab[r][c] == k) model_m[r][7-c] = m_brk;
            for (int a = 0; a < 2; a++)
                if (alias_key[a] == k) model_m[alias_row[a]][alias_col[a]] = m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare of X at the current Y and of the released line drives
    always @(posedge CLKi) begin
        #1;
        if (chk_en) begin
            checks++;
            if (X !== model_m[Y]) begin
                errors++;
                $display("FAIL cmp_x: y=%0d got %h, expected %h (t=%0t)", Y, X, model_m[Y], $time);
            end
`ifndef PS2_HOST_TX_EN
            checks++;
            if ({dataout, clkout} !== 2'b11) begin
                errors++;
                $display("FAIL cmp_lines: got %b%b, expected 11 (t=%0t)", dataout, clkout, $time);
            end
`endif
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLKi);
    endtask

    // One PS/2 bit: data set while pclk high, then a 2 us low pulse
    task automatic clk_bit(input logic v, input bit last);
        @(negedge CLKi);
        data = v;
        cycles(10);
        if (last) chk_en = 1'b0;  // matrix may change after the stop-bit edge
        pclk = 1'b0;
        cycles(20);
        pclk = 1'b1;
        cycles(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) clk_bit(f[i], i == 10);
        data = 1'b1;
        cycles(10);
        if (!bad_par && !bad_stop) model_byte(b);
        chk_en = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) clk_bit(f[i], 1'b0);
        data = 1'b1;
    endtask

    task automatic sweep_y(input string name);
        @(negedge CLKi);
        for (int y = 0; y < 16; y++) begin
            Y = 4'(y);
            #1;
            check(name, X, model_m[y]);
        end
    endtask

    task automatic read_row(input string name, input logic [3:0] y, input logic [7:0] exp);
        @(negedge CLKi);
        Y = y;
        #1;
        check(name, X, exp);
        check({name, "_model"}, model_m[y], exp);
    endtask

    initial begin
        model_reset();
        cycles(3);
        chk_en = 1'b1;
        sweep_y("reset_sweep");
        @(negedge CLKi);
        RST = 1'b0;
        cycles(5);

        send_frame(8'h1C);
        read_row("a_make", 4'd2, 8'hBF);
        read_row("a_make_row3", 4'd3, 8'hFF);

        send_frame(8'hF0);
        send_frame(8'h1C);
        read_row("a_break", 4'd2, 8'hFF);

        send_frame(8'hE0);
        send_frame(8'h75);
        read_row("up_make", 4'd8, 8'hDF);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        read_row("up_break", 4'd8, 8'hFF);

        send_frame(8'h1C, 1'b1, 1'b0);
        read_row("bad_parity", 4'd2, 8'hFF);
        send_frame(8'h1C, 1'b0, 1'b1);
        read_row("bad_stop", 4'd2, 8'hFF);

        send_partial(8'h1C, 5);
        cycles(TIMEOUT + 200);
        send_frame(8'h1C);
        read_row("timeout_recover", 4'd2, 8'hBF);
        send_frame(8'hF0);
        send_frame(8'h1C);
        read_row("timeout_release", 4'd2, 8'hFF);

        send_frame(8'hF0);  // unmapped 00 consumes the break prefix
        send_frame(8'h00);
        send_frame(8'h1C);
        read_row("unmapped_clears", 4'd2, 8'hBF);
        send_frame(8'hF0);  // AA keeps the break prefix pending
        send_frame(8'hAA);
        send_frame(8'h1C);
        read_row("aa_ignored", 4'd2, 8'hFF);
        send_frame(8'hE0);  // E0 1C has no mapping
        send_frame(8'h1C);
        read_row("ext_a_unmapped", 4'd2, 8'hFF);

        send_frame(8'hE0);
        send_frame(8'h11);
        send_frame(8'h11);
        read_row("code_graph", 4'd6, 8'hEB);
        send_frame(8'hE0);
        send_frame(8'h14);
        send_frame(8'h59);
        read_row("ctrl_shift", 4'd6, 8'hE8);
        send_frame(8'hF0);
        send_frame(8'h59);
        read_row("shift_release", 4'd6, 8'hE9);
        send_frame(8'h83);
        read_row("stop_key", 4'd7, 8'hEF);
        send_frame(8'h29);
        read_row("space_key", 4'd8, 8'hFE);
        send_frame(8'h45);
        read_row("zero_key", 4'd0, 8'hFE);
        sweep_y("state_sweep");

        send_frame(8'h12);
        send_frame(8'h1C);
        read_row("pre_reset_a", 4'd2, 8'hBF);
        send_partial(8'h29, 6);
        @(negedge CLKi);
        RST = 1'b1;
        chk_en = 1'b0;
        @(posedge CLKi);
        #1;
        model_reset();
        chk_en = 1'b1;
        cycles(2);
        sweep_y("mid_reset_sweep");
        @(negedge CLKi);
        RST = 1'b0;
        cycles(5);
        send_frame(8'h1C);
        read_row("post_reset_a", 4'd2, 8'hBF);
        read_row("post_reset_row6", 4'd6, 8'hFF);

        cycles(5);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
